morse_gap_timer: RTL and testbench
==================================

MORSE_GAP_TIMER -- requirements
Module: morse_gap_timer

Interface
REQ-001 Parameter CNT_W, default 4: width of the unit counter and of remaining.
REQ-002 Parameter UNIT_DIV, default 1: clock cycles per Morse unit; legal range 1..65535.
REQ-003 Parameter SYM_GAP, default 1: units for the intra-character gap (mode 2'b00).
REQ-004 Parameter LETTER_GAP, default 3: units for the inter-letter gap (mode 2'b01).
REQ-005 Parameter WORD_GAP, default 7: units for the inter-word gap (mode 2'b10).
REQ-006 clock  input  1  sole clock; all state changes on the rising edge.
REQ-007 reset  input  1  asynchronous, active-high reset.
REQ-008 start  input  1  request to begin a gap, sampled on a rising clock edge.
REQ-009 mode  input  2  gap select, sampled with start; 2'b11 is reserved.
REQ-010 abort  input  1  cancels a gap in progress.
REQ-011 busy  output  1  high while a gap is being timed.
REQ-012 done  output  1  single-cycle pulse when a gap completes.
REQ-013 err  output  1  single-cycle pulse when start arrives with reserved mode.
REQ-014 remaining  output  CNT_W  whole units left in the current gap.

Function
REQ-015 The block SHALL implement states IDLE, COUNT and DONE.
REQ-016 Let N be the gap length selected by mode and D be UNIT_DIV. If start is sampled high at edge 0 with a legal mode, the block SHALL enter COUNT, load remaining=N and clear the prescaler.
REQ-017 In COUNT, the prescaler SHALL emit a unit tick every D cycles; each tick SHALL decrement remaining by 1.
REQ-018 busy SHALL be high in cycles 1..N*D after edge 0, and low otherwise.
REQ-019 The tick that takes remaining to 0 SHALL move the state to DONE; done SHALL be high in cycle N*D+1 only, with busy low.
REQ-020 From DONE, the block SHALL return to IDLE on the next edge, unless start is accepted on that edge.
REQ-021 A legal start in COUNT or DONE SHALL retrigger the gap: reload remaining=N, clear the prescaler and suppress any done for the earlier gap.
REQ-022 abort high in COUNT SHALL return the block to IDLE on that edge, set remaining=0 and produce no done; abort in IDLE or DONE has no effect other than REQ-023.
REQ-023 If abort and start are high on the same edge, abort SHALL win and start SHALL be ignored.
REQ-024 A start with mode 2'b11 SHALL leave the state unchanged and pulse err for one cycle.
REQ-025 In IDLE and DONE, remaining SHALL read 0.
REQ-026 The counter SHALL never wrap; decrement SHALL be disabled at 0.
REQ-027 Elaboration SHALL fail if SYM_GAP, LETTER_GAP or WORD_GAP is 0, or does not fit in CNT_W bits, or if UNIT_DIV is 0.

Reset
REQ-028 While reset is high, the block SHALL hold IDLE with busy=0, done=0, err=0, remaining=0 and the prescaler cleared, independent of clock.
REQ-029 Reset asserted mid-gap SHALL abandon the gap with no done; the first edge after reset release SHALL behave as in IDLE.

Structure
REQ-030 The shared package morse_pkg SHALL hold the mode encodings (MODE_SYM, MODE_LETTER, MODE_WORD, MODE_RSVD) and the state enumeration.
REQ-031 The prescaler SHALL be a sub-module, morse_unit_tick, with inputs clock, reset, clear and enable, parameter UNIT_DIV, and a one-cycle tick output.

Verification
REQ-032 D=1, start with mode=01 at edge 0: busy in cycles 1-3, remaining 3,2,1, done in cycle 4 only, then IDLE.
REQ-033 UNIT_DIV=4, start with mode=10: busy in cycles 1-28, done in cycle 29; remaining steps down every 4 cycles.
REQ-034 D=1, mode=10 gap; start with mode=00 at cycle 3: remaining reloads to 1, done in cycle 5 only, and no done from the first gap.
REQ-035 D=1, mode=10 gap; abort at cycle 2, with start high on the same edge: busy low in cycle 3, remaining=0, and no done ever.
REQ-036 Reset asserted asynchronously mid-cycle during a word gap: outputs zero immediately; after release, start with mode=00 gives done in cycle 2.
REQ-037 start with mode=11 in IDLE: err pulses for one cycle, busy stays 0 and done stays 0.

Source files
------------

// File: rtl/morse_pkg.sv
// Shared definitions for the Morse gap timer: mode encodings, FSM states
// and a parameter sanity helper used at elaboration time.
// Contents: MODE_* gap select codes, state_t enum, gap_fits() helper.
package morse_pkg;

    // Gap select codes carried on the mode input alongside start.
    localparam logic [1:0] MODE_SYM    = 2'b00;  // intra-character gap
    localparam logic [1:0] MODE_LETTER = 2'b01;  // inter-letter gap
    localparam logic [1:0] MODE_WORD   = 2'b10;  // inter-word gap
    localparam logic [1:0] MODE_RSVD   = 2'b11;  // reserved, rejected with err

    // Timer control states.
    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_COUNT = 2'd1,
        ST_DONE  = 2'd2
    } state_t;

    // True when a gap length is non-zero and representable in width bits.
    function automatic bit gap_fits(input int units, input int width);
        if (units <= 0) begin
            return 1'b0;
        end
        if (width >= 31) begin
            return 1'b1;
        end
        return (units < (1 << width));
    endfunction

endpackage : morse_pkg

// File: rtl/morse_unit_tick.sv
// Unit prescaler: divides the clock by UNIT_DIV and emits a one-cycle tick
// on the last cycle of every unit while enable is high.
// Ports: clock, reset (async, active-high), clear (restart the unit),
//        enable (count), tick (one-cycle unit strobe, combinational).
module morse_unit_tick #(
    parameter int UNIT_DIV = 1
) (
    input  logic clock,
    input  logic reset,
    input  logic clear,
    input  logic enable,
    output logic tick
);

    // A divide-by-one prescaler still needs a 1-bit register to stay legal.
    localparam int             PW   = (UNIT_DIV > 1) ? $clog2(UNIT_DIV) : 1;
    localparam logic [PW-1:0]  LAST = PW'(UNIT_DIV - 1);

    logic [PW-1:0] r_cnt;
    logic          w_last;

    assign w_last = (r_cnt == LAST);

    // A clear in the same cycle restarts the unit, so no stale tick leaks out.
    assign tick = enable && !clear && w_last;

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_cnt <= '0;
        end else if (clear) begin
            r_cnt <= '0;
        end else if (enable) begin
            if (w_last) begin
                r_cnt <= '0;
            end else begin
                r_cnt <= r_cnt + 1'b1;
            end
        end
    end

endmodule : morse_unit_tick

// File: rtl/morse_gap_timer.sv
// Morse gap timer: times a symbol, letter or word gap of N units, each unit
// UNIT_DIV clocks, and pulses done when the gap elapses.
// Ports: clock, reset (async, active-high); start + mode request a gap,
//        abort cancels it; busy while timing, done/err one-cycle pulses,
//        remaining = whole units left (0 outside COUNT).
module morse_gap_timer
    import morse_pkg::*;
#(
    parameter int CNT_W      = 4,
    parameter int UNIT_DIV   = 1,
    parameter int SYM_GAP    = 1,
    parameter int LETTER_GAP = 3,
    parameter int WORD_GAP   = 7
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             start,
    input  logic [1:0]       mode,
    input  logic             abort,
    output logic             busy,
    output logic             done,
    output logic             err,
    output logic [CNT_W-1:0] remaining
);

    // ------------------------------------------------------------------
    // Elaboration-time parameter checks
    // ------------------------------------------------------------------
    if (!gap_fits(SYM_GAP, CNT_W)) begin : g_bad_sym_gap
        $error("morse_gap_timer: SYM_GAP must be 1..2**CNT_W-1");
    end
    if (!gap_fits(LETTER_GAP, CNT_W)) begin : g_bad_letter_gap
        $error("morse_gap_timer: LETTER_GAP must be 1..2**CNT_W-1");
    end
    if (!gap_fits(WORD_GAP, CNT_W)) begin : g_bad_word_gap
        $error("morse_gap_timer: WORD_GAP must be 1..2**CNT_W-1");
    end
    if (UNIT_DIV < 1 || UNIT_DIV > 65535) begin : g_bad_unit_div
        $error("morse_gap_timer: UNIT_DIV must be 1..65535");
    end

    localparam logic [CNT_W-1:0] N_SYM    = CNT_W'(SYM_GAP);
    localparam logic [CNT_W-1:0] N_LETTER = CNT_W'(LETTER_GAP);
    localparam logic [CNT_W-1:0] N_WORD   = CNT_W'(WORD_GAP);
    localparam logic [CNT_W-1:0] ONE      = CNT_W'(1);

    // ------------------------------------------------------------------
    // State and working signals
    // ------------------------------------------------------------------
    state_t           r_state;
    state_t           w_state_nxt;
    logic [CNT_W-1:0] r_rem;
    logic [CNT_W-1:0] w_rem_nxt;
    logic             r_err;
    logic             w_err_nxt;
    logic [CNT_W-1:0] w_gap_len;
    logic             w_start_ok;
    logic             w_load;
    logic             w_tick;
    logic             w_pre_clear;
    logic             w_pre_en;

    // abort outranks start in every state, including the reserved-mode case.
    assign w_start_ok = start && !abort && (mode != MODE_RSVD);
    assign w_err_nxt  = start && !abort && (mode == MODE_RSVD);

    // Gap length for the requested mode; the reserved code never loads.
    always_comb begin
        w_gap_len = N_SYM;
        case (mode)
            MODE_SYM:    w_gap_len = N_SYM;
            MODE_LETTER: w_gap_len = N_LETTER;
            MODE_WORD:   w_gap_len = N_WORD;
            default:     w_gap_len = N_SYM;
        endcase
    end

    // ------------------------------------------------------------------
    // Unit prescaler
    // ------------------------------------------------------------------
    // Held in clear outside COUNT so every gap starts on a fresh unit, and
    // cleared on a retrigger so the new gap gets full-length units.
    assign w_pre_en    = (r_state == ST_COUNT);
    assign w_pre_clear = w_load || (r_state != ST_COUNT);

    morse_unit_tick #(
        .UNIT_DIV (UNIT_DIV)
    ) u_unit_tick (
        .clock  (clock),
        .reset  (reset),
        .clear  (w_pre_clear),
        .enable (w_pre_en),
        .tick   (w_tick)
    );

    // ------------------------------------------------------------------
    // Next-state / next-count logic
    // ------------------------------------------------------------------
    always_comb begin
        w_state_nxt = r_state;
        w_rem_nxt   = r_rem;
        w_load      = 1'b0;

        case (r_state)
            ST_IDLE: begin
                if (w_start_ok) begin
                    w_load      = 1'b1;
                    w_state_nxt = ST_COUNT;
                    w_rem_nxt   = w_gap_len;
                end
            end

            ST_COUNT: begin
                if (abort) begin
                    w_state_nxt = ST_IDLE;
                    w_rem_nxt   = '0;
                end else if (w_start_ok) begin
                    // Retrigger wins over a coincident final tick, so the
                    // earlier gap never reports done.
                    w_load      = 1'b1;
                    w_state_nxt = ST_COUNT;
                    w_rem_nxt   = w_gap_len;
                end else if (w_tick) begin
                    // Saturating: the decrement is blocked once at zero.
                    if (r_rem <= ONE) begin
                        w_state_nxt = ST_DONE;
                        w_rem_nxt   = '0;
                    end else begin
                        w_rem_nxt   = r_rem - ONE;
                    end
                end
            end

            ST_DONE: begin
                if (w_start_ok) begin
                    w_load      = 1'b1;
                    w_state_nxt = ST_COUNT;
                    w_rem_nxt   = w_gap_len;
                end else begin
                    w_state_nxt = ST_IDLE;
                    w_rem_nxt   = '0;
                end
            end

            default: begin
                w_state_nxt = ST_IDLE;
                w_rem_nxt   = '0;
            end
        endcase
    end

    // ------------------------------------------------------------------
    // Registers
    // ------------------------------------------------------------------
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_state <= ST_IDLE;
            r_rem   <= '0;
            r_err   <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            r_rem   <= w_rem_nxt;
            r_err   <= w_err_nxt;
        end
    end

    // ------------------------------------------------------------------
    // Outputs, all decoded from registered state
    // ------------------------------------------------------------------
    assign busy      = (r_state == ST_COUNT);
    assign done      = (r_state == ST_DONE);
    assign err       = r_err;
    assign remaining = r_rem;

endmodule : morse_gap_timer

// File: tb/tb_morse_gap_timer.sv
// Self-checking bench for morse_gap_timer: two instances (UNIT_DIV=1 and 4)
// driven in turn; expected per-cycle outputs are queued when stimulus is
// applied and popped/compared one entry per clock after each rising edge.
module tb_morse_gap_timer;
    import morse_pkg::*;

    typedef struct packed {
        logic       busy;
        logic       done;
        logic       err;
        logic [3:0] rem;
    } obs_t;

    logic       clock = 1'b0;
    logic       reset;
    logic       start;
    logic       abort;
    logic [1:0] mode;
    logic       sel;      // 0: unit-divide-1 instance, 1: unit-divide-4

    logic       start1, abort1, start4, abort4;
    logic       busy1, done1, err1, busy4, done4, err4;
    logic [3:0] rem1, rem4;
    logic       o_busy, o_done, o_err;
    logic [3:0] o_rem;

    obs_t exp_q[$];
    int   n_vec = 0;
    int   n_err = 0;
    int   cyc_n = 0;

    always #5 clock = ~clock;

    assign start1 = start && !sel;
    assign abort1 = abort && !sel;
    assign start4 = start && sel;
    assign abort4 = abort && sel;

    assign o_busy = sel ? busy4 : busy1;
    assign o_done = sel ? done4 : done1;
    assign o_err  = sel ? err4  : err1;
    assign o_rem  = sel ? rem4  : rem1;

    morse_gap_timer #(.CNT_W(4), .UNIT_DIV(1)) u_d1 (
        .clock     (clock),
        .reset     (reset),
        .start     (start1),
        .mode      (mode),
        .abort     (abort1),
        .busy      (busy1),
        .done      (done1),
        .err       (err1),
        .remaining (rem1)
    );

    morse_gap_timer #(.CNT_W(4), .UNIT_DIV(4)) u_d4 (
        .clock     (clock),
        .reset     (reset),
        .start     (start4),
        .mode      (mode),
        .abort     (abort4),
        .busy      (busy4),
        .done      (done4),
        .err       (err4),
        .remaining (rem4)
    );

    task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s cycle %0d: observed %0h expected %0h", tag, cyc_n, act, exp);
        end
    endtask

    // One clock: sample just after the edge, compare with the queue head
    // (an empty queue means an idle cycle), then drop one-shot inputs.
    task automatic cyc();
        obs_t e;
        @(posedge clock);
        #1;
        cyc_n++;
        e = '0;
        if (exp_q.size() > 0) begin
            e = exp_q.pop_front();
        end
        chk("busy",      o_busy, e.busy);
        chk("done",      o_done, e.done);
        chk("err",       o_err,  e.err);
        chk("remaining", o_rem,  e.rem);
        start = 1'b0;
        abort = 1'b0;
    endtask

    task automatic drain(input int extra);
        while (exp_q.size() > 0) cyc();
        repeat (extra) cyc();
    endtask

    // First k busy cycles of an n-unit gap with d clocks per unit.
    task automatic push_busy(input int n, input int d, input int k);
        obs_t e;
        for (int c = 1; c <= k; c++) begin
            e      = '0;
            e.busy = 1'b1;
            e.rem  = 4'(n - (c - 1) / d);
            exp_q.push_back(e);
        end
    endtask

    task automatic push_done();
        obs_t e;
        e      = '0;
        e.done = 1'b1;
        exp_q.push_back(e);
    endtask

    task automatic push_err_idle();
        obs_t e;
        e     = '0;
        e.err = 1'b1;
        exp_q.push_back(e);
    endtask

    task automatic go(input logic [1:0] m);
        start = 1'b1;
        mode  = m;
    endtask

    initial begin
        reset = 1'b1;
        start = 1'b0;
        abort = 1'b0;
        mode  = 2'b00;
        sel   = 1'b0;

        // Reset state, held across edges.
        repeat (3) cyc();
        reset = 1'b0;
        repeat (2) cyc();

        // Letter gap, one clock per unit.
        go(MODE_LETTER); push_busy(3, 1, 3); push_done(); drain(2);

        // Reserved mode from IDLE: err only.
        go(MODE_RSVD); push_err_idle(); drain(3);

        // Word gap retriggered by a symbol gap on edge 3.
        go(MODE_WORD); push_busy(7, 1, 3);
        repeat (3) cyc();
        go(MODE_SYM); push_busy(1, 1, 1); push_done(); drain(8);

        // Abort with coincident start on edge 2.
        go(MODE_WORD); push_busy(7, 1, 2);
        repeat (2) cyc();
        go(MODE_SYM); abort = 1'b1; drain(10);

        // Retrigger while in DONE: no return to IDLE in between.
        go(MODE_SYM); push_busy(1, 1, 1); push_done();
        repeat (2) cyc();
        go(MODE_LETTER); push_busy(3, 1, 3); push_done(); drain(2);

        // Reserved start during a gap: err pulses, counting undisturbed.
        go(MODE_LETTER); push_busy(3, 1, 3); push_done();
        exp_q[1].err = 1'b1;
        cyc();
        go(MODE_RSVD); drain(2);

        // Abort while idle is inert.
        abort = 1'b1; drain(2);

        // Asynchronous reset in the middle of a word gap.
        go(MODE_WORD); push_busy(7, 1, 3);
        repeat (3) cyc();
        #3 reset = 1'b1;
        #1;
        chk("async_rst_busy", o_busy, 1'b0);
        chk("async_rst_done", o_done, 1'b0);
        chk("async_rst_err",  o_err,  1'b0);
        chk("async_rst_rem",  o_rem,  4'd0);
        repeat (2) cyc();
        reset = 1'b0;
        go(MODE_SYM); push_busy(1, 1, 1); push_done(); drain(10);

        // Four clocks per unit: word gap.
        sel = 1'b1;
        repeat (2) cyc();
        go(MODE_WORD); push_busy(7, 4, 28); push_done(); drain(3);

        // Retrigger mid-unit restarts the prescaler.
        go(MODE_SYM); push_busy(1, 4, 2);
        repeat (2) cyc();
        go(MODE_SYM); push_busy(1, 4, 4); push_done(); drain(3);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule : tb_morse_gap_timer
